csr_access_sequencer: RTL and testbench
=======================================

Name: csr_access_sequencer

Overview:
- Executes Zicsr instructions (CSRRW/S/C and their immediate forms) handed over by the execute stage.
- Drives the CSR unit's read port, its write_enable / write_done handshake and its write data.
- Performs the read-modify-write, returns the old CSR value for rd, and stalls the pipeline while busy.
- Sits directly upstream of the CSR unit, between the execute stage and writeback.

Parameters:
- TIMEOUT, 16: max cycles in WAIT_DONE before the access is aborted as illegal (must be ≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- func3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csr_addr_in  in  12  target CSR address
- rs1_data  in  32  rs1 operand value
- rs1_idx  in  5  rs1 index; also zimm for immediate forms
- rd_idx  in  5  destination register index
- busy  out  1  high in every non-IDLE state; pipeline stall
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; illegal-instruction flag
- rd_we  out  1  valid with done; writeback enable
- rd_idx_out  out  5  latched rd_idx
- rd_data  out  32  old CSR value
- csr_addr  out  12  address to CSR unit; held from READ through DONE
- csr_write_enable  out  1  to CSR unit
- csr_wdata  out  32  to CSR unit csr_data_in
- csr_rdata  in  32  CSR unit combinational read data
- csr_write_done  in  1  CSR unit write acknowledge; registered, arrives 1 cycle after write_enable

Behaviour:
- Reset (async, active-high): FSM to IDLE; all outputs 0; latched operands 0. Reset during WRITE or WAIT_DONE aborts the access, and no done is produced.
- States: IDLE, READ, WRITE, WAIT_DONE, DONE.
- IDLE:
  - If start is high, latch func3, csr_addr_in, rs1_data, rs1_idx, rd_idx.
  - If latched func3[1:0]==00, go to DONE with illegal=1.
  - Otherwise go to READ.
- READ (1 cycle):
  - csr_addr = latched address; capture csr_rdata as old.
  - src = func3[2] ? {27'b0, rs1_idx} : rs1_data.
  - new value: RW = src; RS = old | src; RC = old & ~src.
  - do_write = RW, or (RS/RC with rs1_idx != 0); the rs1_idx test applies to both register and immediate forms.
  - If do_write and csr_addr[11:10]==2'b11 (read-only space), go to DONE with illegal=1.
  - Else if do_write, go to WRITE; otherwise go to DONE.
- WRITE (exactly 1 cycle): csr_write_enable=1, csr_wdata = new value; next state WAIT_DONE.
- WAIT_DONE:
  - csr_write_enable=0; csr_wdata held.
  - On csr_write_done, go to DONE.
  - The timeout counter counts cycles in this state; when it reaches TIMEOUT without an ack, go to DONE with illegal=1.
- DONE (1 cycle):
  - done=1.
  - rd_we = !illegal && rd_idx != 0.
  - rd_data = old (0 when illegal).
  - Return to IDLE.
- Latency from the start cycle to done high:
  - write path: 4 cycles;
  - read-only path (no write): 2 cycles;
  - func3 illegal: 1 cycle.
- Repeat requests:
  - start while busy is ignored; the requester must hold the instruction until done.
  - Back-to-back: start accepted in the IDLE cycle right after DONE.
- rd write rules:
  - CSRRW with rd=x0 still writes the CSR; rd_we stays 0.
  - A CSR write is never issued when illegal is set.
- A csr_write_done seen outside WAIT_DONE is ignored.

Test Plan:
1. MSCRATCH (0x340) holds 0xDEADBEEF; CSRRW rs1_data=0x12345678, rd=5 -> one write_enable pulse with wdata 0x12345678; done 4 cycles after start; rd_we=1, rd_idx_out=5, rd_data=0xDEADBEEF.
2. MSTATUS=0x0000000F; CSRRCI zimm=0x3, rd=0 -> wdata 0x0000000C; rd_we=0; illegal=0.
3. CSRRS on CYCLE (0xC00) with rs1_idx=0, rd=7 -> no write_enable; done 2 cycles after start; rd_data equals the cycle value sampled in READ.
4. CSRRW to 0xC00 with rs1_idx=1 -> no write_enable; done with illegal=1 and rd_we=0. Separately, func3=100 -> done in 1 cycle with illegal=1.
5. Hold csr_write_done low with TIMEOUT=16 -> done after 16 WAIT_DONE cycles with illegal=1. Separately, assert reset in WAIT_DONE -> all outputs 0 immediately, no done pulse, next start handled normally.
6. start held high continuously -> exactly one access per 4-cycle write sequence (busy masks start); second access accepted the cycle after DONE.

Source files
------------

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer
//
// Runs one Zicsr instruction (CSRRW/RS/RC and the immediate forms) against
// the CSR unit. It reads the old value, does the read-modify-write with a
// write_enable / write_done handshake, returns the old value for rd, and
// holds busy high so the pipeline stalls for the whole access.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               request pulse, only looked at in IDLE
//   func3               Zicsr funct3 (001 RW, 010 RS, 011 RC, 1xx immediate)
//   csr_addr_in         target CSR address
//   rs1_data, rs1_idx   source operand; rs1_idx doubles as zimm
//   rd_idx              destination register index
//   busy                high in every non-IDLE state
//   done                one-cycle completion pulse
//   illegal, rd_we      qualified by done
//   rd_idx_out          latched rd_idx
//   rd_data             old CSR value (0 when illegal)
//   csr_addr            address to the CSR unit, held from READ through DONE
//   csr_write_enable    one-cycle write strobe to the CSR unit
//   csr_wdata           write data, held until the access completes
//   csr_rdata           combinational read data from the CSR unit
//   csr_write_done      registered write acknowledge from the CSR unit
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; operands latched on start
// S_READ     | csr_addr driven, old value captured, new value computed
// S_WRITE    | csr_write_enable pulse with the new value
// S_WAIT_DONE| waiting for csr_write_done, bounded by TIMEOUT cycles
// S_DONE     | done pulse with illegal / rd_we / rd_data

module csr_access_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [11:0] csr_addr_in,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rd_idx,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        rd_we,
    output logic [4:0]  rd_idx_out,
    output logic [31:0] rd_data,
    output logic [11:0] csr_addr,
    output logic        csr_write_enable,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic        csr_write_done
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [4:0]  rs1_idx_q, rs1_idx_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] old_q, old_d;
    logic [31:0] wdata_q, wdata_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        rd_we_q, rd_we_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        we_q, we_d;

    logic [31:0] src;
    logic [31:0] new_val;
    logic        do_write;

    // Operand and modified value, evaluated against the latched instruction;
    // only consumed in READ, where csr_rdata is the old value.
    always_comb begin
        src = func3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;
        case (func3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = csr_rdata | src;
            default: new_val = csr_rdata & ~src;
        endcase
        // Set/clear with x0 (or zimm 0) is a pure read and must not write.
        do_write = (func3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    end

    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        rs1_data_d = rs1_data_q;
        rs1_idx_d  = rs1_idx_q;
        rd_idx_d   = rd_idx_q;
        csr_addr_d = csr_addr_q;
        old_d      = old_q;
        wdata_d    = wdata_q;
        tmr_d      = tmr_q;
        we_d       = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    func3_d    = func3;
                    rs1_data_d = rs1_data;
                    rs1_idx_d  = rs1_idx;
                    rd_idx_d   = rd_idx;
                    csr_addr_d = csr_addr_in;
                    if (func3[1:0] == 2'b00) begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                old_d = csr_rdata;
                if (do_write && (csr_addr_q[11:10] == 2'b11)) begin
                    state_d   = S_DONE;
                    illegal_d = 1'b1;
                end else if (do_write) begin
                    state_d = S_WRITE;
                    wdata_d = new_val;
                    we_d    = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                state_d = S_WAIT_DONE;
                tmr_d   = TW'(TIMEOUT - 1);
            end
            S_WAIT_DONE: begin
                // An ack on the last allowed cycle still counts as success.
                if (csr_write_done) begin
                    state_d = S_DONE;
                end else if (tmr_q == '0) begin
                    state_d   = S_DONE;
                    illegal_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                csr_addr_d = '0;
                wdata_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_we_d   = done_d && !illegal_d && (rd_idx_d != 5'd0);
        rd_data_d = (done_d && !illegal_d) ? old_d : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            func3_q    <= '0;
            rs1_data_q <= '0;
            rs1_idx_q  <= '0;
            rd_idx_q   <= '0;
            csr_addr_q <= '0;
            old_q      <= '0;
            wdata_q    <= '0;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_data_q  <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            rs1_data_q <= rs1_data_d;
            rs1_idx_q  <= rs1_idx_d;
            rd_idx_q   <= rd_idx_d;
            csr_addr_q <= csr_addr_d;
            old_q      <= old_d;
            wdata_q    <= wdata_d;
            tmr_q      <= tmr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            rd_we_q    <= rd_we_d;
            rd_data_q  <= rd_data_d;
            we_q       <= we_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign illegal          = illegal_q;
    assign rd_we            = rd_we_q;
    assign rd_idx_out       = rd_idx_q;
    assign rd_data          = rd_data_q;
    assign csr_addr         = csr_addr_q;
    assign csr_write_enable = we_q;
    assign csr_wdata        = wdata_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
module tb_csr_access_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func3 = '0;
    logic [11:0] csr_addr_in = '0;
    logic [31:0] rs1_data = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic        busy, done, illegal, rd_we;
    logic [4:0]  rd_idx_out;
    logic [31:0] rd_data;
    logic [11:0] csr_addr;
    logic        csr_write_enable;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_write_done;

    csr_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .func3(func3),
        .csr_addr_in(csr_addr_in), .rs1_data(rs1_data), .rs1_idx(rs1_idx),
        .rd_idx(rd_idx), .busy(busy), .done(done), .illegal(illegal),
        .rd_we(rd_we), .rd_idx_out(rd_idx_out), .rd_data(rd_data),
        .csr_addr(csr_addr), .csr_write_enable(csr_write_enable),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_write_done(csr_write_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Free-running cycle count; also serves as the CYCLE CSR (0xC00).
    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // CSR unit model: combinational read, registered write acknowledge.
    bit          ack_en = 1'b1;
    bit          spur_ack = 1'b0;
    logic        ack_q;
    logic [31:0] mem [4096];

    always @(posedge clk) begin
        if (reset) begin
            ack_q          <= 1'b0;
            mem[12'h340]   <= 32'hDEADBEEF;
            mem[12'h300]   <= 32'h0000000F;
            mem[12'h341]   <= 32'h0;
        end else begin
            if (csr_write_enable && ack_en) mem[csr_addr] <= csr_wdata;
            ack_q <= csr_write_enable && ack_en;
        end
    end

    assign csr_rdata      = (csr_addr == 12'hC00) ? cyc : mem[csr_addr];
    assign csr_write_done = ack_q | spur_ack;

    // Reference CSR contents as the bench expects them after each access.
    logic [31:0] ref_mem [4096];

    task automatic init_ref();
        for (int k = 0; k < 4096; k++) ref_mem[k] = 32'h0;
        ref_mem[12'h340] = 32'hDEADBEEF;
        ref_mem[12'h300] = 32'h0000000F;
    endtask

    typedef struct {
        logic [31:0] start_cyc;
        int          lat;
        logic        illegal;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        int          writes;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a,
                                   input logic [31:0] d, input logic [4:0] i,
                                   input logic [4:0] r, input logic [31:0] sc);
        exp_t e;
        logic [31:0] old, src, nv;
        logic dw;
        e.start_cyc = sc; e.rd = r; e.illegal = 1'b0; e.rd_we = 1'b0;
        e.rd_data = 32'h0; e.writes = 0; e.wdata = 32'h0; e.lat = 0;
        if (f3[1:0] == 2'b00) begin
            e.lat = 1; e.illegal = 1'b1;
            return e;
        end
        old = (a == 12'hC00) ? sc + 32'd1 : ref_mem[a];
        src = f3[2] ? {27'b0, i} : d;
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        dw = (f3[1:0] == 2'b01) || (i != 5'd0);
        if (dw && a[11:10] == 2'b11) begin
            e.lat = 2; e.illegal = 1'b1;
        end else if (dw) begin
            e.writes = 1; e.wdata = nv;
            if (ack_en) begin
                e.lat = 4; e.rd_data = old; e.rd_we = (r != 5'd0);
                ref_mem[a] = nv;
            end else begin
                e.lat = TIMEOUT + 3; e.illegal = 1'b1;
            end
        end else begin
            e.lat = 2; e.rd_data = old; e.rd_we = (r != 5'd0);
        end
        return e;
    endfunction

    // Output monitor: counts write strobes and checks every done pulse.
    int          wr_count = 0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (reset) begin
            wr_count = 0;
        end else begin
            if (csr_write_enable) begin
                wr_count++;
                last_wdata = csr_wdata;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.start_cyc, 32'(e.lat));
                    chk("illegal", {31'b0, illegal}, {31'b0, e.illegal});
                    chk("rd_we", {31'b0, rd_we}, {31'b0, e.rd_we});
                    chk("rd_idx_out", {27'b0, rd_idx_out}, {27'b0, e.rd});
                    chk("rd_data", rd_data, e.rd_data);
                    chk("busy_in_done", {31'b0, busy}, 32'd1);
                    chk("write_count", 32'(wr_count), 32'(e.writes));
                    if (e.writes > 0) chk("wdata", last_wdata, e.wdata);
                end
                wr_count = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] d, input logic [4:0] i,
                         input logic [4:0] r, input bit expect_it);
        @(negedge clk);
        func3 = f3; csr_addr_in = a; rs1_data = d; rs1_idx = i; rd_idx = r;
        start = 1'b1;
        if (expect_it) sb.push_back(model(f3, a, d, i, r, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_busy"}, {31'b0, busy}, 32'd0);
        chk({pfx, "_done"}, {31'b0, done}, 32'd0);
        chk({pfx, "_illegal"}, {31'b0, illegal}, 32'd0);
        chk({pfx, "_rd_we"}, {31'b0, rd_we}, 32'd0);
        chk({pfx, "_rd_idx_out"}, {27'b0, rd_idx_out}, 32'd0);
        chk({pfx, "_rd_data"}, rd_data, 32'd0);
        chk({pfx, "_csr_addr"}, {20'b0, csr_addr}, 32'd0);
        chk({pfx, "_we"}, {31'b0, csr_write_enable}, 32'd0);
        chk({pfx, "_wdata"}, csr_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_ref();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // CSRRW mscratch, rd=5
        issue(3'b001, 12'h340, 32'h12345678, 5'd1, 5'd5, 1'b1);
        drain("t1_drain");
        // CSRRCI mstatus zimm=3, rd=0
        issue(3'b111, 12'h300, 32'h0, 5'd3, 5'd0, 1'b1);
        drain("t2_drain");
        // CSRRS cycle with x0, rd=7; a stray ack must not disturb a read-only access
        spur_ack = 1'b1;
        issue(3'b010, 12'hC00, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b1);
        drain("t3_drain");
        spur_ack = 1'b0;
        // CSRRW to read-only space
        issue(3'b001, 12'hC00, 32'h1, 5'd1, 5'd4, 1'b1);
        drain("t4a_drain");
        // reserved funct3
        issue(3'b100, 12'h340, 32'h1, 5'd1, 5'd8, 1'b1);
        drain("t4b_drain");
        // CSRRS register form, then CSRRC with x0 but nonzero data (no write), CSRRSI zimm=0
        issue(3'b010, 12'h340, 32'h000000F0, 5'd2, 5'd9, 1'b1);
        drain("rs_drain");
        issue(3'b011, 12'h340, 32'hFFFFFFFF, 5'd0, 5'd10, 1'b1);
        drain("rc_x0_drain");
        issue(3'b110, 12'h300, 32'h0, 5'd0, 5'd11, 1'b1);
        drain("rsi0_drain");

        // Write never acknowledged: timeout
        ack_en = 1'b0;
        issue(3'b001, 12'h341, 32'h00000055, 5'd1, 5'd4, 1'b1);
        drain("t5a_drain");

        // Reset while in WAIT_DONE aborts without a done pulse
        issue(3'b001, 12'h341, 32'h00000077, 5'd1, 5'd2, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        init_ref();
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(3'b001, 12'h341, 32'h0000A5A5, 5'd1, 5'd6, 1'b1);
        drain("post_reset_drain");

        // start held high: one access per sequence, next accepted right after DONE
        @(negedge clk);
        func3 = 3'b001; csr_addr_in = 12'h340; rs1_data = 32'hCAFEF00D;
        rs1_idx = 5'd3; rd_idx = 5'd3;
        start = 1'b1;
        sb.push_back(model(3'b001, 12'h340, 32'hCAFEF00D, 5'd3, 5'd3, cyc));
        sb.push_back(model(3'b001, 12'h340, 32'hCAFEF00D, 5'd3, 5'd3, cyc + 32'd5));
        repeat (6) @(negedge clk);
        start = 1'b0;
        drain("t6_drain");

        repeat (6) @(negedge clk);
        chk("final_idle_busy", {31'b0, busy}, 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
